// File: rtl/pipe_pkg.sv
// Shared definitions for the 4-stage pipeline controller: opcodes, FSM states,
// forward-select encodings and the shadow-slot record tracked per stage.
package pipe_pkg;

    localparam int REG_W = 3;

    localparam logic [1:0] OP_LI   = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             writes;
        logic [REG_W-1:0] rd;
    } slot_t;

    // A slot can supply a value only for a live instruction that writes the register read.
    function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid && s.writes && (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX operand forwarding: compares the ID read registers against
// the EX and WB shadow slots, the nearer (EX) producer taking priority.
module hazard_fwd_unit
    import pipe_pkg::*;
(
    input  logic             rd_a_en,
    input  logic [REG_W-1:0] rd_a,
    input  logic             rd_b_en,
    input  logic [REG_W-1:0] rd_b,
    input  slot_t            ex_slot,
    input  slot_t            wb_slot,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (rd_a_en) begin
            if (slot_hit(ex_slot, rd_a)) begin
                fwd_a = FWD_EX;
            end else if (slot_hit(wb_slot, rd_a)) begin
                fwd_a = FWD_WB;
            end
        end
        if (rd_b_en) begin
            if (slot_hit(ex_slot, rd_b)) begin
                fwd_b = FWD_EX;
            end else if (slot_hit(wb_slot, rd_b)) begin
                fwd_b = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing and hazard controller for the IF/ID/EX/WB core: post-reset fill
// hold, jump redirect with one-cycle flush, shadow slots, forwarding and WB write.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int INIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       instr_id,
    input  logic             stall_in,
    output logic             pc_en,
    output logic             pc_load,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             reg_we,
    output logic [REG_W-1:0] wb_rd,
    output state_e           state_dbg
);

    localparam logic [3:0] CNT_LAST = 4'(INIT_CYCLES - 1);

    logic [1:0]       op;
    logic [REG_W-1:0] rd_f;
    logic [REG_W-1:0] rs_f;
    logic             id_valid;
    logic             rd_a_en;
    logic             rd_b_en;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    slot_t      ex_q, ex_d;
    slot_t      wb_q, wb_d;

    assign op   = instr_id[7:6];
    assign rd_f = instr_id[5:3];
    assign rs_f = instr_id[2:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_d       = ex_q;
        wb_d       = wb_q;
        id_valid   = 1'b0;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        ifid_en    = !stall_in;
        ifid_flush = 1'b0;

        case (state_q)
            HOLD: begin
                ifid_flush = 1'b1;
                if (!stall_in) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            RUN: begin
                id_valid = 1'b1;
                pc_en    = !stall_in;
                // A stalled jump waits; it is taken in the first unstalled cycle.
                if (op == OP_JMP && !stall_in) begin
                    pc_load    = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = FLUSH;
                end
            end
            FLUSH: begin
                // IF/ID holds the wrong-path fetch, so ID is treated as empty.
                pc_en      = !stall_in;
                ifid_flush = 1'b1;
                if (!stall_in) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase

        if (!stall_in) begin
            wb_d = ex_q;
            ex_d = '0;
            if (id_valid && op != OP_JMP) begin
                ex_d = '{valid: 1'b1, writes: 1'b1, rd: rd_f};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            ex_q    <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            wb_q    <= wb_d;
        end
    end

    assign rd_a_en = id_valid && (op == OP_ADDI || op == OP_ADD);
    assign rd_b_en = id_valid && (op == OP_ADD);

    hazard_fwd_unit u_fwd (
        .rd_a_en (rd_a_en),
        .rd_a    (rd_f),
        .rd_b_en (rd_b_en),
        .rd_b    (rs_f),
        .ex_slot (ex_q),
        .wb_slot (wb_q),
        .fwd_a   (fwd_a),
        .fwd_b   (fwd_b)
    );

    // Suppressed during a stall so the held WB instruction is written only once.
    assign reg_we    = wb_q.valid && wb_q.writes && !stall_in;
    assign wb_rd     = wb_q.rd;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// stall / jump / reset sequences and random traffic against a reference model.
module tb_pipeline_ctrl;

    localparam int INIT = 2;

    logic             clk;
    logic             reset;
    logic [7:0]       instr_id;
    logic             stall_in;
    logic             pc_en;
    logic             pc_load;
    logic             ifid_en;
    logic             ifid_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             reg_we;
    logic [2:0]       wb_rd;
    pipe_pkg::state_e state_dbg;

    int n_checks;
    int n_errors;

    pipeline_ctrl #(.INIT_CYCLES(INIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_id   (instr_id),
        .stall_in   (stall_in),
        .pc_en      (pc_en),
        .pc_load    (pc_load),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .reg_we     (reg_we),
        .wb_rd      (wb_rd),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // History of instructions that left ID, newest first: entry k is the
    // producer (k+1) instructions ahead of the one now in ID.
    typedef struct {
        bit       wr;
        bit [2:0] rd;
    } ent_t;

    ent_t hist[$];
    int   m_hold_left;   // fill-hold edges still to go
    bit   m_wrong_path;  // the instruction now in ID is a wrong-path fetch
    bit   m_jump;

    logic       e_pc_en, e_pc_load, e_ifid_en, e_ifid_flush, e_reg_we;
    logic [1:0] e_fwd_a, e_fwd_b;
    logic [2:0] e_wb_rd;

    function automatic void model_reset();
        ent_t empty;
        empty.wr = 1'b0;
        empty.rd = 3'd0;
        hist.delete();
        hist.push_back(empty);
        hist.push_back(empty);
        m_hold_left  = INIT;
        m_wrong_path = 1'b0;
        m_jump       = 1'b0;
    endfunction

    function automatic logic [1:0] producer_sel(input bit reads, input bit [2:0] r);
        if (!reads) return 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (hist[k].wr && hist[k].rd == r) return (k == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic void model_expect(input logic [7:0] ins, input logic stall);
        bit       in_hold;
        bit       idv;
        bit [1:0] op;
        in_hold      = (m_hold_left > 0);
        idv          = !in_hold && !m_wrong_path;
        op           = ins[7:6];
        m_jump       = idv && op == 2'd3 && !stall;
        e_pc_en      = !in_hold && !stall;
        e_pc_load    = m_jump;
        e_ifid_en    = !stall;
        e_ifid_flush = in_hold || m_wrong_path || m_jump;
        e_fwd_a      = producer_sel(idv && (op == 2'd1 || op == 2'd2), ins[5:3]);
        e_fwd_b      = producer_sel(idv && op == 2'd2, ins[2:0]);
        e_reg_we     = !stall && hist[1].wr;
        e_wb_rd      = hist[1].rd;
    endfunction

    function automatic void model_advance(input logic [7:0] ins, input logic stall);
        ent_t e;
        bit   idv;
        if (stall) return;
        idv  = (m_hold_left == 0) && !m_wrong_path;
        e.wr = idv && ins[7:6] != 2'd3;
        e.rd = ins[5:3];
        if (m_hold_left > 0) m_hold_left--;
        m_wrong_path = m_jump;
        hist.push_front(e);
        void'(hist.pop_back());
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs (called at negedge), then check against the model.
    task automatic drive_check(input logic [7:0] ins, input logic stall);
        instr_id = ins;
        stall_in = stall;
        #1;
        model_expect(ins, stall);
        chk("pc_en", 8'(pc_en), 8'(e_pc_en));
        chk("pc_load", 8'(pc_load), 8'(e_pc_load));
        chk("ifid_en", 8'(ifid_en), 8'(e_ifid_en));
        chk("ifid_flush", 8'(ifid_flush), 8'(e_ifid_flush));
        chk("fwd_a", 8'(fwd_a), 8'(e_fwd_a));
        chk("fwd_b", 8'(fwd_b), 8'(e_fwd_b));
        chk("reg_we", 8'(reg_we), 8'(e_reg_we));
        if (hist[1].wr) chk("wb_rd", 8'(wb_rd), 8'(e_wb_rd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance(instr_id, stall_in);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc_en"}, 8'(pc_en), 8'd0);
        chk({tag, "_pc_load"}, 8'(pc_load), 8'd0);
        chk({tag, "_ifid_en"}, 8'(ifid_en), 8'd1);
        chk({tag, "_ifid_flush"}, 8'(ifid_flush), 8'd1);
        chk({tag, "_fwd_a"}, 8'(fwd_a), 8'd0);
        chk({tag, "_fwd_b"}, 8'(fwd_b), 8'd0);
        chk({tag, "_reg_we"}, 8'(reg_we), 8'd0);
        chk({tag, "_wb_rd"}, 8'(wb_rd), 8'd0);
        chk({tag, "_state"}, 8'(state_dbg), 8'(pipe_pkg::HOLD));
    endtask

    task automatic fill_hold(input string tag);
        for (int i = 0; i < INIT; i++) begin
            drive_check(8'h00, 1'b0);
            chk({tag, "_hold_pc_en"}, 8'(pc_en), 8'd0);
            chk({tag, "_hold_flush"}, 8'(ifid_flush), 8'd1);
            chk({tag, "_hold_reg_we"}, 8'(reg_we), 8'd0);
            tick();
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] instr;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       we;
        logic [2:0] rd;
        logic       ld;
        logic       fl;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{8'h0B, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0}; // li r1,3
        tbl[1]  = '{8'h49, 2'b01, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0}; // addi r1: EX fwd
        tbl[2]  = '{8'h91, 2'b00, 2'b01, 1'b1, 3'd1, 1'b0, 1'b0}; // add r2,r1: rs hits EX
        tbl[3]  = '{8'h89, 2'b10, 2'b10, 1'b1, 3'd1, 1'b0, 1'b0}; // add r1,r1: WB fwd
        tbl[4]  = '{8'h0B, 2'b00, 2'b00, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[5]  = '{8'h0B, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[6]  = '{8'h89, 2'b01, 2'b01, 1'b1, 3'd1, 1'b0, 1'b0}; // EX priority
        tbl[7]  = '{8'h0B, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[8]  = '{8'h10, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{8'h18, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[10] = '{8'h20, 2'b00, 2'b00, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[11] = '{8'h89, 2'b00, 2'b00, 1'b1, 3'd3, 1'b0, 1'b0}; // producer long gone
        tbl[12] = '{8'hC5, 2'b00, 2'b00, 1'b1, 3'd4, 1'b1, 1'b1}; // jump
        tbl[13] = '{8'h0B, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b1}; // wrong path
        tbl[14] = '{8'h49, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0}; // target, bubbles behind
        tbl[15] = '{8'h49, 2'b01, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0}; // wrong path never written
        tbl[16] = '{8'hC5, 2'b00, 2'b00, 1'b1, 3'd1, 1'b1, 1'b1}; // jump
        tbl[17] = '{8'hC5, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 1'b1}; // jump in FLUSH ignored
        tbl[18] = '{8'h0B, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        stall_in = 1'b0;
        instr_id = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b0;
        fill_hold("init");

        for (int i = 0; i < 19; i++) begin
            drive_check(tbl[i].instr, 1'b0);
            chk($sformatf("tbl%0d_pc_en", i), 8'(pc_en), 8'd1);
            chk($sformatf("tbl%0d_fwd_a", i), 8'(fwd_a), 8'(tbl[i].fa));
            chk($sformatf("tbl%0d_fwd_b", i), 8'(fwd_b), 8'(tbl[i].fb));
            chk($sformatf("tbl%0d_reg_we", i), 8'(reg_we), 8'(tbl[i].we));
            if (tbl[i].we) chk($sformatf("tbl%0d_wb_rd", i), 8'(wb_rd), 8'(tbl[i].rd));
            chk($sformatf("tbl%0d_pc_load", i), 8'(pc_load), 8'(tbl[i].ld));
            chk($sformatf("tbl%0d_flush", i), 8'(ifid_flush), 8'(tbl[i].fl));
            tick();
        end

        // Stall freeze with a producer (li r1) in EX.
        drive_check(8'h0B, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_check(8'h49, 1'b1);
            chk("stall_fwd_a", 8'(fwd_a), 8'd1);
            chk("stall_pc_en", 8'(pc_en), 8'd0);
            chk("stall_ifid_en", 8'(ifid_en), 8'd0);
            chk("stall_reg_we", 8'(reg_we), 8'd0);
            tick();
        end
        drive_check(8'h49, 1'b0);
        chk("resume_fwd_a", 8'(fwd_a), 8'd1);
        chk("resume_reg_we", 8'(reg_we), 8'd1);
        chk("resume_wb_rd", 8'(wb_rd), 8'd1);
        tick();
        drive_check(8'h89, 1'b0);
        chk("resume_add_fwd_a", 8'(fwd_a), 8'd1);
        chk("resume_add_fwd_b", 8'(fwd_b), 8'd1);
        tick();

        // A jump seen under stall is taken once the stall drops.
        drive_check(8'hC5, 1'b1);
        chk("stalled_jmp_load", 8'(pc_load), 8'd0);
        tick();
        drive_check(8'hC5, 1'b0);
        chk("released_jmp_load", 8'(pc_load), 8'd1);
        tick();

        // Reset asserted mid-FLUSH, away from any clock edge.
        drive_check(8'h0B, 1'b0);
        chk("flush_before_rst", 8'(ifid_flush), 8'd1);
        chk("flush_state", 8'(state_dbg), 8'(pipe_pkg::FLUSH));
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        fill_hold("rehold");
        drive_check(8'h0B, 1'b0);
        chk("after_rehold_pc_en", 8'(pc_en), 8'd1);
        tick();

        // Random traffic, registers biased to r0..r3 so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ins;
            logic       st;
            ins = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
            st  = ($urandom_range(0, 4) == 0);
            drive_check(ins, st);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
